group_update_sequencer: RTL and testbench

// - Generates the graph-colour group index that drives the p-bit update-order LUT. The LUT expands this

---
 rtl/pbit_seq_pkg.sv | 6 +
 rtl/dwell_counter.sv | 24 ++
 rtl/group_update_sequencer.sv | 111 +++++++++++
 tb/tb_group_update_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pbit_seq_pkg.sv
// Shared types and defaults for the p-bit group update sequencer.
package pbit_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
   localparam int NUM_GROUPS_DEF = 5;
   localparam int GROUP_W_DEF    = 3;
endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter; 'last' flags the final cycle of the loaded dwell.
module dwell_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] value,
   output logic         last
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (en && !last)
         cnt <= cnt - 1'b1;
   end

   assign last = (cnt <= W'(1));
endmodule

// File: rtl/group_update_sequencer.sv
// Steps colour-group index 0..NUM_GROUPS-1 with a programmable dwell and counts sweeps.
// Optional macro UPDATE_GAP_EN inserts one invalid bubble cycle before each group.
module group_update_sequencer
   import pbit_seq_pkg::*;
#(
   parameter int NUM_GROUPS = NUM_GROUPS_DEF,
   parameter int GROUP_W    = GROUP_W_DEF,
   parameter int DWELL_W    = 8,
   parameter int SWEEP_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic [SWEEP_W-1:0] num_sweeps,
   output logic [0:GROUP_W-1] group_EN,
   output logic               group_valid,
   output logic               sweep_done,
   output logic [SWEEP_W-1:0] sweep_count,
   output logic               busy,
   output logic               done
);
   seq_state_t state, state_nxt;
   logic [DWELL_W-1:0] dwell_q;
   logic [SWEEP_W-1:0] sweeps_q, count_q, count_inc;
   logic [GROUP_W-1:0] group_q;
   logic stop_q, bubble, active, last, grp_last, sweep_end, finish, accept;

   assign accept    = (state == IDLE) && start;
   assign active    = (state == RUN) && !bubble;
   assign grp_last  = active && last;
   assign sweep_end = grp_last && (group_q == GROUP_W'(NUM_GROUPS - 1));
   assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
   // A stop arriving on the sweep-end cycle itself still ends the run here.
   assign finish    = sweep_end && (((sweeps_q != '0) && (count_inc == sweeps_q)) || stop_q || stop);

`ifdef UPDATE_GAP_EN
   logic gap_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         gap_q <= 1'b0;
      else if (accept || grp_last)
         gap_q <= 1'b1;
      else if (state == RUN)
         gap_q <= 1'b0;
   end
   assign bubble = gap_q;
`else
   assign bubble = 1'b0;
`endif

   dwell_counter #(.W(DWELL_W)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept || grp_last),
      .en    (active),
      .value (accept ? ((dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles) : dwell_q),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_q  <= '0;
         sweeps_q <= '0;
         count_q  <= '0;
         group_q  <= '0;
         stop_q   <= 1'b0;
      end else if (accept) begin
         dwell_q  <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
         sweeps_q <= num_sweeps;
         count_q  <= '0;
         group_q  <= '0;
         stop_q   <= 1'b0;
      end else if (state == RUN) begin
         if (stop)
            stop_q <= 1'b1;
         if (sweep_end)
            count_q <= count_inc;
         if (grp_last)
            group_q <= (group_q == GROUP_W'(NUM_GROUPS - 1)) ? '0 : group_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (finish) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      group_valid = (state == RUN) && !bubble;
      sweep_done  = sweep_end;
      busy        = (state != IDLE);
      done        = (state == DONE);
   end

   assign group_EN    = group_q;
   assign sweep_count = count_q;
endmodule

// File: tb/tb_group_update_sequencer.sv
// Scoreboard bench: expected group sequence is queued at start and popped on each valid cycle.
module tb_group_update_sequencer;
   localparam int NG = 5, GW = 3, DW = 8, SW = 16;
`ifdef UPDATE_GAP_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
   logic [DW-1:0] dwell_cycles = '0;
   logic [SW-1:0] num_sweeps = '0;
   logic [0:GW-1] group_EN;
   logic group_valid, sweep_done, busy, done;
   logic [SW-1:0] sweep_count;

   int total = 0, bad = 0;
   int exp_q[$];
   int n_valid, n_sdone, n_done, done_cyc, cnt_at_done;

   group_update_sequencer #(.NUM_GROUPS(NG), .GROUP_W(GW), .DWELL_W(DW), .SWEEP_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .dwell_cycles(dwell_cycles), .num_sweeps(num_sweeps),
      .group_EN(group_EN), .group_valid(group_valid), .sweep_done(sweep_done),
      .sweep_count(sweep_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Runs one job; stop is pulsed on the first valid cycle of stop_grp in sweep stop_sw.
   task automatic run_job(input int dw, input int ns, input int stop_sw, input int stop_grp,
                          input int restart_at);
      int eff_sw, eff_dw, run_len, budget, e;
      bit stopped, seen_done;
      eff_dw  = (dw == 0) ? 1 : dw;
      eff_sw  = (ns != 0) ? ns : stop_sw;
      run_len = eff_sw * NG * (eff_dw + GAP);
      exp_q.delete();
      for (int s = 0; s < eff_sw; s++)
         for (int g = 0; g < NG; g++)
            for (int d = 0; d < eff_dw; d++) exp_q.push_back(g);
      n_valid = 0; n_sdone = 0; n_done = 0; done_cyc = -1; cnt_at_done = -1;
      stopped = 0; seen_done = 0;
      budget = run_len + 20;
      @(negedge clk);
      dwell_cycles = DW'(dw); num_sweeps = SW'(ns); start = 1'b1;
      for (int c = 1; c <= budget && !seen_done; c++) begin
         @(negedge clk);
         start = 1'b0; stop = 1'b0;
         if (c == 1) begin
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %0b want 1", busy); end
         end
         if (c == restart_at) begin
            start = 1'b1; dwell_cycles = DW'(dw + 5); num_sweeps = SW'(ns + 3);
         end
         if (stop_grp >= 0 && !stopped && n_sdone == stop_sw - 1 && group_valid && int'(group_EN) == stop_grp) begin
            stop = 1'b1; stopped = 1;
         end
         if (group_valid) begin
            n_valid++; total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL sb_extra: got group %0d want no valid cycle", group_EN);
            end else begin
               e = exp_q.pop_front();
               if (int'(group_EN) !== e) begin
                  bad++; $display("FAIL sb_group: got %0d want %0d (valid #%0d)", group_EN, e, n_valid);
               end
            end
         end
         if (sweep_done) n_sdone++;
         if (done) begin
            n_done++; seen_done = 1; done_cyc = c; cnt_at_done = int'(sweep_count);
         end
      end
      if (!seen_done) begin total++; bad++; $display("FAIL timeout: no done within %0d cycles", budget); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL sb_missing: %0d groups left want 0", exp_q.size()); end
      total++;
      if (done_cyc !== run_len + 1) begin bad++; $display("FAIL done_cycle: got %0d want %0d", done_cyc, run_len + 1); end
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || group_valid !== 1'b0) begin
         bad++; $display("FAIL idle_after: busy=%0b done=%0b valid=%0b want 0 0 0", busy, done, group_valid);
      end
      dwell_cycles = '0; num_sweeps = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({group_valid, sweep_done, busy, done} !== 4'b0 || group_EN !== '0 || sweep_count !== '0) begin
         bad++; $display("FAIL reset_vals: v=%0b sd=%0b b=%0b d=%0b g=%0d c=%0d want all 0",
                         group_valid, sweep_done, busy, done, group_EN, sweep_count);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || group_valid !== 1'b0) begin bad++; $display("FAIL idle_hold: busy=%0b valid=%0b want 0 0", busy, group_valid); end
   endtask

   task automatic test_single_sweep;
      run_job(1, 1, 0, -1, -1);
      total++;
      if (n_sdone !== 1 || n_done !== 1) begin bad++; $display("FAIL single_pulses: sweep_done=%0d done=%0d want 1 1", n_sdone, n_done); end
      total++;
      if (cnt_at_done !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", cnt_at_done); end
   endtask

   task automatic test_multi_sweep;
      run_job(3, 2, 0, -1, -1);
      total++;
      if (n_valid !== 30) begin bad++; $display("FAIL multi_valid: got %0d want 30", n_valid); end
      total++;
      if (n_sdone !== 2 || cnt_at_done !== 2) begin bad++; $display("FAIL multi_sweeps: pulses=%0d count=%0d want 2 2", n_sdone, cnt_at_done); end
   endtask

   task automatic test_dwell_zero;
      run_job(0, 1, 0, -1, -1);
      total++;
      if (n_valid !== 5 || cnt_at_done !== 1) begin bad++; $display("FAIL dwell_zero: valid=%0d count=%0d want 5 1", n_valid, cnt_at_done); end
   endtask

   task automatic test_stop_freerun;
      run_job(3, 0, 4, 2, -1);
      total++;
      if (cnt_at_done !== 4 || n_sdone !== 4) begin bad++; $display("FAIL stop_mid: count=%0d pulses=%0d want 4 4", cnt_at_done, n_sdone); end
   endtask

   task automatic test_stop_at_sweep_end;
      run_job(1, 0, 2, NG - 1, -1);
      total++;
      if (cnt_at_done !== 2) begin bad++; $display("FAIL stop_end: count=%0d want 2", cnt_at_done); end
   endtask

   task automatic test_stop_in_idle;
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      run_job(1, 2, 0, -1, -1);
      total++;
      if (cnt_at_done !== 2) begin bad++; $display("FAIL idle_stop: count=%0d want 2", cnt_at_done); end
   endtask

   task automatic test_restart_ignored;
      run_job(2, 2, 0, -1, 4);
      total++;
      if (n_valid !== 20 || cnt_at_done !== 2 || n_done !== 1) begin
         bad++; $display("FAIL restart: valid=%0d count=%0d done=%0d want 20 2 1", n_valid, cnt_at_done, n_done);
      end
   endtask

   task automatic test_gap_pattern;
      run_job(2, 1, 0, -1, -1);
      total++;
      if (n_valid !== 10) begin bad++; $display("FAIL gap_valid: got %0d want 10", n_valid); end
   endtask

   task automatic test_async_reset;
      int seen;
      seen = 0;
      @(negedge clk);
      dwell_cycles = 8'd2; num_sweeps = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12 + 5 * GAP) @(negedge clk);
      total++;
      if (busy !== 1'b1 || sweep_count !== 16'd1) begin bad++; $display("FAIL midrun: busy=%0b count=%0d want 1 1", busy, sweep_count); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({group_valid, sweep_done, busy, done} !== 4'b0 || group_EN !== '0 || sweep_count !== '0) begin
         bad++; $display("FAIL async_reset: v=%0b sd=%0b b=%0b d=%0b g=%0d c=%0d want all 0",
                         group_valid, sweep_done, busy, done, group_EN, sweep_count);
      end
      repeat (3) begin @(negedge clk); if (done || busy) seen++; end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done || busy) seen++; end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL no_done_after_reset: %0d active cycles want 0", seen); end
      dwell_cycles = '0; num_sweeps = '0;
   endtask

   initial begin
      test_reset();
      test_single_sweep();
      test_multi_sweep();
      test_dwell_zero();
      test_stop_freerun();
      test_stop_at_sweep_end();
      test_stop_in_idle();
      test_restart_ignored();
      test_gap_pattern();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
